// File: rtl/int_to_float.sv
// Iterative 32-bit integer to IEEE-754 single converter; normalizes one bit per
// cycle and truncates the fraction to match the truncating adder downstream.
module int_to_float #(
    parameter bit SIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] debug
);

    localparam int DATA_W = 32;
    localparam logic [7:0] EXP_TOP = 8'd158;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   mag;
    logic [7:0]          exp;
    logic                sign;
    logic [7:0]          shcnt;
    logic                accept;
    logic                in_sign;

    // Two's-complement magnitude; the most negative value maps onto itself,
    // which is the correct unsigned magnitude 2^31.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic neg);
        logic signed [DATA_W-1:0] sv;
        sv = signed'(v);
        magnitude = neg ? unsigned'(-sv) : v;
    endfunction

    // Truncating pack: the bits below the 23-bit fraction are simply dropped.
    function automatic logic [31:0] pack_trunc(input logic s, input logic [7:0] e,
                                               input logic [22:0] frac);
        pack_trunc = {s, e, frac};
    endfunction

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign in_sign  = SIGNED ? in_data[DATA_W-1] : 1'b0;
    assign debug    = {24'b0, shcnt};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = NORM;
            NORM: if (mag == '0 || mag[DATA_W-1]) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mag       <= '0;
            exp       <= '0;
            sign      <= 1'b0;
            shcnt     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign  <= in_sign;
                        mag   <= magnitude(in_data, in_sign);
                        exp   <= EXP_TOP;
                        shcnt <= '0;
                    end
                end
                NORM: begin
                    if (mag == '0) begin
                        out_data  <= 32'h0000_0000;
                        out_valid <= 1'b1;
                    end else if (mag[DATA_W-1]) begin
                        out_data  <= pack_trunc(sign, exp, mag[30:8]);
                        out_valid <= 1'b1;
                    end else begin
                        mag   <= mag << 1;
                        exp   <= exp - 8'd1;
                        shcnt <= shcnt + 8'd1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_float.sv
// Directed-vector bench for int_to_float: one signed and one unsigned instance,
// table of conversions plus backpressure and mid-conversion reset sequences.
module tb_int_to_float;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid_s, in_valid_u;
    logic        out_ready;
    logic        in_ready_s, in_ready_u, out_valid_s, out_valid_u;
    logic [31:0] out_data_s, out_data_u, debug_s, debug_u;

    logic        sel_u;
    logic        in_ready, out_valid;
    logic [31:0] out_data, debug;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    int_to_float #(.SIGNED(1'b1)) dut_s (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid_s),
        .in_ready(in_ready_s), .out_data(out_data_s), .out_valid(out_valid_s),
        .out_ready(out_ready), .debug(debug_s)
    );

    int_to_float #(.SIGNED(1'b0)) dut_u (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid_u),
        .in_ready(in_ready_u), .out_data(out_data_u), .out_valid(out_valid_u),
        .out_ready(out_ready), .debug(debug_u)
    );

    assign in_ready  = sel_u ? in_ready_u  : in_ready_s;
    assign out_valid = sel_u ? out_valid_u : out_valid_s;
    assign out_data  = sel_u ? out_data_u  : out_data_s;
    assign debug     = sel_u ? debug_u     : debug_s;

    typedef struct {
        bit          uns;
        logic [31:0] din;
        logic [31:0] dout;
        int          lat;
        int          dbg;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic set_valid(input logic v);
        if (sel_u) in_valid_u = v;
        else       in_valid_s = v;
    endtask

    // Accept d at edge E0 and return the edge index at which out_valid is seen.
    task automatic accept_and_wait(input logic [31:0] d, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        in_data = d;
        set_valid(1'b1);
        @(posedge clk);
        @(negedge clk);
        set_valid(1'b0);
        in_data = 32'hDEAD_BEEF;
        chk("in_ready_after_accept", {31'b0, in_ready}, 32'd0);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        string tag;
        sel_u = v.uns;
        accept_and_wait(v.din, lat);
        tag = $sformatf("vec%0d", idx);
        chk({tag, "_latency"}, lat, v.lat);
        chk({tag, "_out_data"}, out_data, v.dout);
        chk({tag, "_debug"}, debug, v.dbg);
    endtask

    initial begin
        int lat;
        bit seen;

        vecs[0] = '{1'b0, 32'h0000_0001, 32'h3F80_0000, 32, 31};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'hBF80_0000, 32, 31};
        vecs[2] = '{1'b0, 32'h8000_0000, 32'hCF00_0000, 1, 0};
        vecs[3] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1, 0};
        vecs[4] = '{1'b0, 32'h7FFF_FFFF, 32'h4EFF_FFFF, 2, 1};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'h4F7F_FFFF, 1, 0};
        vecs[6] = '{1'b1, 32'h0000_0003, 32'h4040_0000, 31, 30};
        vecs[7] = '{1'b0, 32'h0000_0005, 32'h40A0_0000, 30, 29};
        vecs[8] = '{1'b1, 32'h8000_0000, 32'h4F00_0000, 1, 0};
        vecs[9] = '{1'b0, 32'hFFFF_FFFE, 32'hC000_0000, 31, 30};

        sel_u      = 1'b0;
        reset      = 1'b1;
        in_data    = '0;
        in_valid_s = 1'b0;
        in_valid_u = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        chk("reset_debug", debug, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Backpressure: result must hold and a stray in_valid must be ignored.
        sel_u     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        accept_and_wait(32'h0000_0005, lat);
        chk("bp_latency", lat, 30);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                in_data    = 32'h0000_0007;
                in_valid_s = 1'b1;
            end else begin
                in_valid_s = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            in_valid_s = 1'b0;
            chk($sformatf("bp_hold_data_c%0d", c), out_data, 32'h40A0_0000);
            chk($sformatf("bp_hold_valid_c%0d", c), {31'b0, out_valid}, 32'd1);
            chk($sformatf("bp_in_ready_c%0d", c), {31'b0, in_ready}, 32'd0);
        end
        chk("bp_debug_kept", debug, 32'd29);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_valid", {31'b0, out_valid}, 32'd0);
        chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);

        // Reset in the middle of normalization aborts without a result.
        in_data    = 32'h0000_0001;
        in_valid_s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_s = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_debug", debug, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_output", {31'b0, seen}, 32'd0);
        run_vec('{1'b0, 32'h0000_0002, 32'h4000_0000, 31, 30}, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
